// File: rtl/vx_commit_pkt_arbiter.sv
// vx_commit_pkt_arbiter: round-robin, packet-locked arbiter that merges NUM_REQS commit
// streams onto one commit port through a single-entry output register.
// A packet runs from the first beat taken in IDLE up to its eop beat. Beats from other
// sources are never interleaved with it, and the round-robin pointer moves only when
// a packet completes.
// Optional feature macro: VX_COMMIT_ARB_PERF_EN adds the stall and packet counters.
module vx_commit_pkt_arbiter #(
  parameter int unsigned NUM_REQS   = 4,
  parameter int unsigned DATAW      = 64,
  parameter int unsigned PERF_CTR_W = 44,
  localparam int unsigned IdxW      = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       req_valid,
  input  logic [NUM_REQS*DATAW-1:0] req_data,
  input  logic [NUM_REQS-1:0]       req_sop,
  input  logic [NUM_REQS-1:0]       req_eop,
  output logic [NUM_REQS-1:0]       req_ready,
  output logic                      out_valid,
  output logic [DATAW-1:0]          out_data,
  output logic                      out_sop,
  output logic                      out_eop,
  output logic [IdxW-1:0]           out_idx,
  input  logic                      out_ready,
  output logic                      lock_active
`ifdef VX_COMMIT_ARB_PERF_EN
  ,
  output logic [PERF_CTR_W-1:0]     perf_stall_cycles,
  output logic [PERF_CTR_W-1:0]     perf_packets
`endif
);

  typedef enum logic {StIdle, StLocked} state_e;

  state_e            r_state;
  logic [IdxW-1:0]   r_rr_ptr;
  logic [IdxW-1:0]   r_lock_idx;
  logic              r_out_valid;
  logic [DATAW-1:0]  r_out_data;
  logic              r_out_sop;
  logic              r_out_eop;
  logic [IdxW-1:0]   r_out_idx;

  state_e            w_state_nxt;
  logic [IdxW-1:0]   w_rr_nxt;
  logic [IdxW-1:0]   w_lock_nxt;
  logic              w_found;
  logic [IdxW-1:0]   w_pick;
  int unsigned       w_j;
  logic [IdxW-1:0]   w_sel;
  logic [IdxW-1:0]   w_sel_inc;
  logic              w_load_en;
  logic [NUM_REQS-1:0] w_ready;
  logic              w_accept;
  logic [DATAW-1:0]  w_sel_data;
  logic              w_sel_sop;
  logic              w_sel_eop;

  // The output slot can take a new beat when it is empty or being drained this cycle.
  assign w_load_en = !r_out_valid || out_ready;

  // Round-robin search for the first valid source starting at the pointer.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_j     = 0;
    for (int i = 0; i < int'(NUM_REQS); i++) begin
      w_j = (int'(r_rr_ptr) + i) % NUM_REQS;
      if (!w_found && req_valid[w_j]) begin
        w_found = 1'b1;
        w_pick  = IdxW'(w_j);
      end
    end
  end

  // Selected source: the locked owner while a packet is in flight, else the rr winner.
  always_comb begin
    w_sel      = (r_state == StLocked) ? r_lock_idx : w_pick;
    w_sel_inc  = (w_sel == IdxW'(NUM_REQS - 1)) ? '0 : w_sel + IdxW'(1);
    w_sel_data = req_data[w_sel*DATAW +: DATAW];
    w_sel_sop  = req_sop[w_sel];
    w_sel_eop  = req_eop[w_sel];
  end

  // Ready goes to the owner even when it is not valid, so nothing else can slip in.
  always_comb begin
    w_ready = '0;
    if (w_load_en && ((r_state == StLocked) || w_found)) begin
      w_ready[w_sel] = 1'b1;
    end
  end

  assign req_ready = w_ready;
  assign w_accept  = |(req_valid & w_ready);

  // Packet tracking: lock on a non-eop beat, release and advance the pointer on eop.
  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr_ptr;
    w_lock_nxt  = r_lock_idx;
    if (w_accept) begin
      if (w_sel_eop) begin
        w_state_nxt = StIdle;
        w_rr_nxt    = w_sel_inc;
      end else if (r_state == StIdle) begin
        w_state_nxt = StLocked;
        w_lock_nxt  = w_sel;
      end
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= StIdle;
      r_rr_ptr   <= '0;
      r_lock_idx <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_nxt;
      r_lock_idx <= w_lock_nxt;
    end
  end

  // Output pipeline register; payload only changes when a beat is taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sop   <= 1'b0;
      r_out_eop   <= 1'b0;
      r_out_idx   <= '0;
    end else if (w_load_en) begin
      r_out_valid <= w_accept;
      if (w_accept) begin
        r_out_data <= w_sel_data;
        r_out_sop  <= w_sel_sop;
        r_out_eop  <= w_sel_eop;
        r_out_idx  <= w_sel;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_sop     = r_out_sop;
  assign out_eop     = r_out_eop;
  assign out_idx     = r_out_idx;
  assign lock_active = (r_state == StLocked);

`ifdef VX_COMMIT_ARB_PERF_EN
  logic [PERF_CTR_W-1:0] r_perf_stall;
  logic [PERF_CTR_W-1:0] r_perf_pkts;

  // Stall: someone is waiting but no handshake; packets: eop beats leaving the port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perf_stall <= '0;
      r_perf_pkts  <= '0;
    end else begin
      if ((|req_valid) && !w_accept) begin
        r_perf_stall <= r_perf_stall + PERF_CTR_W'(1);
      end
      if (r_out_valid && out_ready && r_out_eop) begin
        r_perf_pkts <= r_perf_pkts + PERF_CTR_W'(1);
      end
    end
  end

  assign perf_stall_cycles = r_perf_stall;
  assign perf_packets      = r_perf_pkts;
`else
  // Counter width has no effect when the counters are compiled out.
  if (PERF_CTR_W == 0) begin : g_perf_w_unused
  end
`endif

endmodule

// File: tb/tb_vx_commit_pkt_arbiter.sv
// Directed testbench for vx_commit_pkt_arbiter (NUM_REQS=4, DATAW=64).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_vx_commit_pkt_arbiter;

  logic         clk;
  logic         reset;
  logic [3:0]   req_valid;
  logic [255:0] req_data;
  logic [3:0]   req_sop;
  logic [3:0]   req_eop;
  logic [3:0]   req_ready;
  logic         out_valid;
  logic [63:0]  out_data;
  logic         out_sop;
  logic         out_eop;
  logic [1:0]   out_idx;
  logic         out_ready;
  logic         lock_active;
`ifdef VX_COMMIT_ARB_PERF_EN
  logic [43:0]  perf_stall_cycles;
  logic [43:0]  perf_packets;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  vx_commit_pkt_arbiter #(
    .NUM_REQS   (4),
    .DATAW      (64),
    .PERF_CTR_W (44)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_sop     (req_sop),
    .req_eop     (req_eop),
    .req_ready   (req_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_sop     (out_sop),
    .out_eop     (out_eop),
    .out_idx     (out_idx),
    .out_ready   (out_ready),
    .lock_active (lock_active)
`ifdef VX_COMMIT_ARB_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_packets      (perf_packets)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; req_valid = '0; req_data = '0; req_sop = '0; req_eop = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({out_valid, out_sop, out_eop, out_idx, out_data} !== 69'd0)
      $display("FAIL reset_outputs: got v=%0b idx=%0d data=%h want all zero",
               out_valid, out_idx, out_data);
    else n_pass++;
    n_checks++;
    if (lock_active !== 1'b0) $display("FAIL reset_lock: got %0b want 0", lock_active);
    else n_pass++;
    reset = 1'b1;
    tick; tick;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL idle_valid: got %0b want 0", out_valid);
    else n_pass++;
    n_checks++;
    if (req_ready !== 4'b0000) $display("FAIL idle_ready: got %b want 0000", req_ready);
    else n_pass++;
    n_checks++;
    if (lock_active !== 1'b0) $display("FAIL idle_lock: got %0b want 0", lock_active);
    else n_pass++;
`ifdef VX_COMMIT_ARB_PERF_EN
    n_checks++;
    if ({perf_stall_cycles, perf_packets} !== 88'd0)
      $display("FAIL perf_reset: got stall=%0d pkts=%0d want 0 0",
               perf_stall_cycles, perf_packets);
    else n_pass++;
`endif
  endtask

  task automatic test_round_robin;
    for (int i = 0; i < 4; i++) req_data[i*64 +: 64] = 64'h100 + 64'(i);
    req_sop = 4'hF; req_eop = 4'hF; req_valid = 4'hF;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) $display("FAIL rr_first_ready: got %b want 0001", req_ready);
    else n_pass++;
    for (int k = 0; k < 8; k++) begin
      tick;
      n_checks++;
      if ({out_valid, out_idx, out_data} !== {1'b1, 2'(k % 4), 64'h100 + 64'(k % 4)})
        $display("FAIL rr_beat%0d: got v=%0b idx=%0d data=%h want v=1 idx=%0d data=%h",
                 k, out_valid, out_idx, out_data, k % 4, 64'h100 + 64'(k % 4));
      else n_pass++;
    end
    req_valid = '0;
    tick;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL rr_drain: got %0b want 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_packet_lock;
    // Single beat from src0 moves the pointer to 1.
    req_valid = 4'b0001; req_sop = 4'b0001; req_eop = 4'b0001;
    req_data[0 +: 64] = 64'hA0;
    tick;
    req_valid = 4'b0111; req_sop = 4'b0111; req_eop = 4'b0101;
    req_data[0 +: 64] = 64'hA1; req_data[64 +: 64] = 64'h110; req_data[128 +: 64] = 64'h200;
    #1;
    n_checks++;
    if (req_ready !== 4'b0010) $display("FAIL lock_b0_ready: got %b want 0010", req_ready);
    else n_pass++;
    tick;
    n_checks++;
    if ({out_valid, out_idx, out_sop, out_eop, out_data} !== {1'b1, 2'd1, 1'b1, 1'b0, 64'h110})
      $display("FAIL lock_b0_out: got idx=%0d sop=%0b eop=%0b data=%h want 1 1 0 110",
               out_idx, out_sop, out_eop, out_data);
    else n_pass++;
    req_sop = 4'b0101; req_data[64 +: 64] = 64'h111;
    #1;
    n_checks++;
    if ({lock_active, req_ready} !== {1'b1, 4'b0010})
      $display("FAIL lock_b1_ready: got lock=%0b ready=%b want 1 0010", lock_active, req_ready);
    else n_pass++;
    tick;
    n_checks++;
    if ({out_idx, out_sop, out_eop, out_data} !== {2'd1, 1'b0, 1'b0, 64'h111})
      $display("FAIL lock_b1_out: got idx=%0d sop=%0b eop=%0b data=%h want 1 0 0 111",
               out_idx, out_sop, out_eop, out_data);
    else n_pass++;
    req_eop = 4'b0111; req_data[64 +: 64] = 64'h112;
    #1;
    n_checks++;
    if ({lock_active, req_ready} !== {1'b1, 4'b0010})
      $display("FAIL lock_b2_ready: got lock=%0b ready=%b want 1 0010", lock_active, req_ready);
    else n_pass++;
    tick;
    n_checks++;
    if ({out_idx, out_sop, out_eop, out_data, lock_active} !== {2'd1, 1'b0, 1'b1, 64'h112, 1'b0})
      $display("FAIL lock_b2_out: got idx=%0d eop=%0b data=%h lock=%0b want 1 1 112 0",
               out_idx, out_eop, out_data, lock_active);
    else n_pass++;
    req_valid = 4'b0101;
    #1;
    n_checks++;
    if (req_ready !== 4'b0100) $display("FAIL lock_next_ready: got %b want 0100", req_ready);
    else n_pass++;
    tick;
    n_checks++;
    if ({out_valid, out_idx, out_data} !== {1'b1, 2'd2, 64'h200})
      $display("FAIL lock_next_out: got idx=%0d data=%h want 2 200", out_idx, out_data);
    else n_pass++;
    req_valid = '0;
    tick;
  endtask

  task automatic test_backpressure;
    // Pointer is at 3 now; src3 sends a 4-beat packet.
    req_valid = 4'b1000; req_sop = 4'b1000; req_eop = 4'b0000;
    req_data[192 +: 64] = 64'h300;
    tick;
    req_sop = 4'b0000; req_data[192 +: 64] = 64'h301;
    tick;
    out_ready = 1'b0; req_data[192 +: 64] = 64'h302;
    #1;
    n_checks++;
    if (req_ready !== 4'b0000) $display("FAIL bp_ready_drop: got %b want 0000", req_ready);
    else n_pass++;
    for (int k = 0; k < 5; k++) begin
      tick;
      n_checks++;
      if ({out_valid, out_idx, out_data, req_ready, lock_active} !==
          {1'b1, 2'd3, 64'h301, 4'b0000, 1'b1})
        $display("FAIL bp_hold%0d: got v=%0b idx=%0d data=%h ready=%b lock=%0b want 1 3 301 0000 1",
                 k, out_valid, out_idx, out_data, req_ready, lock_active);
      else n_pass++;
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b1000) $display("FAIL bp_release_ready: got %b want 1000", req_ready);
    else n_pass++;
    tick;
    n_checks++;
    if ({out_valid, out_idx, out_eop, out_data} !== {1'b1, 2'd3, 1'b0, 64'h302})
      $display("FAIL bp_beat2: got v=%0b eop=%0b data=%h want 1 0 302", out_valid, out_eop, out_data);
    else n_pass++;
    req_eop = 4'b1000; req_data[192 +: 64] = 64'h303;
    tick;
    n_checks++;
    if ({out_valid, out_eop, out_data, lock_active} !== {1'b1, 1'b1, 64'h303, 1'b0})
      $display("FAIL bp_beat3: got v=%0b eop=%0b data=%h lock=%0b want 1 1 303 0",
               out_valid, out_eop, out_data, lock_active);
    else n_pass++;
    req_valid = '0;
    tick;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL bp_drain: got %0b want 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_reset_mid_packet;
    // Move pointer to 1, then lock onto src3.
    req_valid = 4'b0001; req_sop = 4'b0001; req_eop = 4'b0001;
    req_data[0 +: 64] = 64'hB0;
    tick;
    req_valid = 4'b1000; req_sop = 4'b1000; req_eop = 4'b0000;
    req_data[192 +: 64] = 64'h3A0;
    #1;
    n_checks++;
    if (req_ready !== 4'b1000) $display("FAIL rst_pick3: got %b want 1000", req_ready);
    else n_pass++;
    tick;
    n_checks++;
    if ({lock_active, out_idx} !== {1'b1, 2'd3})
      $display("FAIL rst_locked: got lock=%0b idx=%0d want 1 3", lock_active, out_idx);
    else n_pass++;
    #2;
    reset = 1'b0;
    req_valid = '0;
    #1;
    n_checks++;
    if ({out_valid, lock_active} !== 2'b00)
      $display("FAIL rst_async: got v=%0b lock=%0b want 0 0", out_valid, lock_active);
    else n_pass++;
    tick; tick;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) req_data[i*64 +: 64] = 64'h400 + 64'(i);
    req_valid = 4'hF; req_sop = 4'hF; req_eop = 4'hF;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) $display("FAIL rst_first_ready: got %b want 0001", req_ready);
    else n_pass++;
    tick;
    n_checks++;
    if ({out_valid, out_idx, out_data} !== {1'b1, 2'd0, 64'h400})
      $display("FAIL rst_first_grant: got v=%0b idx=%0d data=%h want 1 0 400",
               out_valid, out_idx, out_data);
    else n_pass++;
    req_valid = '0;
    tick;
  endtask

`ifdef VX_COMMIT_ARB_PERF_EN
  task automatic test_perf;
    reset = 1'b0;
    req_valid = '0;
    #2;
    reset = 1'b1;
    req_valid = 4'b0001; req_sop = 4'b0001; req_eop = 4'b0000;
    req_data[0 +: 64] = 64'hC0; out_ready = 1'b0;
    tick;
    req_sop = 4'b0000; req_eop = 4'b0001; req_data[0 +: 64] = 64'hC1;
    repeat (4) tick;
    out_ready = 1'b1;
    tick;
    req_valid = '0;
    tick;
    n_checks++;
    if (perf_stall_cycles !== 44'd4)
      $display("FAIL perf_stall: got %0d want 4", perf_stall_cycles);
    else n_pass++;
    n_checks++;
    if (perf_packets !== 44'd1) $display("FAIL perf_packets: got %0d want 1", perf_packets);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset;
    test_round_robin;
    test_packet_lock;
    test_backpressure;
    test_reset_mid_packet;
`ifdef VX_COMMIT_ARB_PERF_EN
    test_perf;
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/vx_commit_pkt_arbiter.md
Name: vx_commit_pkt_arbiter

Overview:
- Round-robin, packet-locked arbiter that shares one commit port among NUM_REQS commit sources (execute-unit commit streams) ahead of the per-issue-slot commit gather stage.
- Multi-beat commit packets (sop..eop, one beat per thread-lane group) from one source are never interleaved with beats from another source.
- A single-entry output pipeline register decouples the arbitration path from the downstream ready.

Parameters:
- NUM_REQS, 4, number of commit sources (≥1).
- DATAW, 64, opaque per-beat payload width, excluding sop/eop.
- PERF_CTR_W, 44, width of the performance counters (only used with the optional feature).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- req_valid  in  NUM_REQS  per-source beat valid.
- req_data  in  NUM_REQS*DATAW  per-source payload; source i occupies bits [i*DATAW +: DATAW].
- req_sop  in  NUM_REQS  per-source first beat of packet.
- req_eop  in  NUM_REQS  per-source last beat of packet.
- req_ready  out  NUM_REQS  per-source beat accepted.
- out_valid  out  1  output beat valid.
- out_data  out  DATAW  output payload.
- out_sop  out  1  output first beat.
- out_eop  out  1  output last beat.
- out_idx  out  LOG2UP(NUM_REQS)  index of the source that produced the beat.
- out_ready  in  1  downstream accept.
- lock_active  out  1  a multi-beat packet is in flight (state LOCKED).

Behaviour:
- Reset (reset==0, asynchronous): out_valid=0, out_data/out_sop/out_eop/out_idx=0, state=IDLE, rr_ptr=0, lock_idx=0, lock_active=0.
- Reset asserted mid-packet discards the partial packet. After reset the arbiter restarts in IDLE with no memory of the discarded packet.
- load_en = !out_valid || out_ready. The output register loads whenever load_en and a beat is accepted.
- If load_en is true and no beat is accepted, out_valid falls to 0 on the next edge.
- State IDLE:
  - pick = first i with req_valid[i], searching rr_ptr, rr_ptr+1, … modulo NUM_REQS.
  - req_ready[pick] = load_en. All other req_ready bits are 0.
  - On acceptance with eop=0: state→LOCKED, lock_idx=pick.
  - On acceptance with eop=1 (single-beat packet): stay in IDLE, rr_ptr=(pick+1) mod NUM_REQS.
  - The first beat accepted in IDLE is treated as the packet start regardless of its sop value; sop is passed through unmodified.
- State LOCKED:
  - req_ready[lock_idx] = load_en. All other req_ready bits are 0, even if lock_idx is not valid.
  - On accepting an eop beat: state→IDLE, rr_ptr=(lock_idx+1) mod NUM_REQS.
- rr_ptr advances only on packet completion, never on individual beats.
- Latency: accepted beat appears on out_* exactly 1 cycle later.
- Throughput: 1 beat/cycle sustained while out_ready=1, including back-to-back packets from different sources. No bubble is inserted at a packet boundary.
- req_ready may depend combinationally on req_valid and out_ready. out_* depend on registers only.
- Output holds stable while out_valid && !out_ready.
- NUM_REQS==1: arbitration degenerates to pass-through with the register. out_idx is 1 bit and is always 0.
- lock_active == (state==LOCKED).

Optional Feature:
- Macro: VX_COMMIT_ARB_PERF_EN.
- Defined: adds outputs perf_stall_cycles [PERF_CTR_W] and perf_packets [PERF_CTR_W], both reset to 0.
  - perf_stall_cycles increments each cycle where |req_valid is true and no req_valid&req_ready handshake occurs.
  - perf_packets increments on each out_valid&out_ready&out_eop.
  - Both counters wrap modulo 2^PERF_CTR_W.
- Undefined: the ports and counters are absent. Behaviour of all other ports is identical.

Test Plan:
- Reset then idle, NUM_REQS=4: all req_valid=0, out_ready=1 → out_valid=0, req_ready=0000, lock_active=0.
- Round-robin: all 4 sources offer single-beat packets (sop=eop=1) continuously, out_ready=1 → out_idx sequence 0,1,2,3,0,… with one beat per cycle.
- Packet lock: src1 sends 3 beats (sop,-,eop) while src0/src2 stay valid → out_idx=1 for 3 consecutive beats. The next winner is src2, and lock_active=1 during the 2nd and 3rd acceptance cycles.
- Backpressure: out_ready=0 for 5 cycles mid-packet → out_data held constant, req_ready all 0. On release, beats resume with no loss or duplication.
- Reset mid-packet: assert reset after src3's sop beat → out_valid=0, state IDLE. With all sources then valid, the first grant after release goes to src0.
- Perf (macro defined): src0 valid with out_valid=1 held and out_ready=0 for 4 cycles, then one 2-beat packet drains → perf_stall_cycles=4, perf_packets=1.
